// File: rtl/lb_pkg.sv
// Shared constants and helpers for the 3-row line buffer.
// Optional row tagging is enabled with the LB_ROW_CNT_EN macro.
package lb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int FIRST_ROW  = 2;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_buffer_3row_line_mem.sv
// One image line of storage: synchronous write, combinational read
// that returns the pre-write contents during a same-address write.
module line_mem
  import lb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 5,
  parameter int AW     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/line_buffer_3row.sv
// Raster-to-column converter: emits rows r-2, r-1, r per column.
// Define LB_ROW_CNT_EN to add the row_o output tag.
module line_buffer_3row
  import lb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COLS   = 5,
  parameter int ROWS   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] S1_o,
  output logic [DATA_W-1:0] S2_o,
  output logic [DATA_W-1:0] S3_o,
  output logic              done_o,
  output logic              progress_done_o
`ifdef LB_ROW_CNT_EN
  ,
  output logic [cnt_w(ROWS)-1:0] row_o
`endif
);

  localparam int CW = cnt_w(COLS);
  localparam int RW = cnt_w(ROWS);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] s1_q, s1_d;
  logic [DATA_W-1:0] s2_q, s2_d;
  logic [DATA_W-1:0] s3_q, s3_d;
  logic              done_q, done_d;
  logic              prog_q, prog_d;
  logic [DATA_W-1:0] a_rd, b_rd;
  logic              last_col, last_row;

  // lineA holds row r-1, lineB row r-2; both shift on every accepted pixel
  line_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (COLS),
    .AW     (CW)
  ) u_line_a (
    .clk     (clk),
    .we_i    (done_i),
    .addr_i  (col_q),
    .wdata_i (data_i),
    .rdata_o (a_rd)
  );

  line_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (COLS),
    .AW     (CW)
  ) u_line_b (
    .clk     (clk),
    .we_i    (done_i),
    .addr_i  (col_q),
    .wdata_i (a_rd),
    .rdata_o (b_rd)
  );

  assign last_col = (col_q == CW'(COLS - 1));
  assign last_row = (row_q == RW'(ROWS - 1));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    s3_d   = s3_q;
    done_d = 1'b0;
    prog_d = 1'b0;
    if (done_i) begin
      s1_d   = b_rd;
      s2_d   = a_rd;
      s3_d   = data_i;
      done_d = (row_q >= RW'(FIRST_ROW));
      prog_d = last_row && last_col;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      done_q <= 1'b0;
      prog_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      done_q <= done_d;
      prog_q <= prog_d;
    end
  end

  assign S1_o            = s1_q;
  assign S2_o            = s2_q;
  assign S3_o            = s3_q;
  assign done_o          = done_q;
  assign progress_done_o = prog_q;

`ifdef LB_ROW_CNT_EN
  logic [RW-1:0] row_out_q, row_out_d;

  always_comb begin
    row_out_d = row_out_q;
    if (done_i) begin
      row_out_d = row_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_out_q <= '0;
    end else begin
      row_out_q <= row_out_d;
    end
  end

  assign row_o = row_out_q;
`endif

endmodule
